decade_chain_ctrl: RTL and testbench
====================================

# decade_chain_ctrl

Run/stop/clear controller for a cascaded chain of BCD decade counters. It owns the NDIG-digit count register and gates count requests into it according to a four-state FSM. It flags chain wrap-around or saturation on a registered carry pulse. It sits between the front-panel command inputs (start/stop/clear) and the display datapath, so multi-digit counting is sequenced in one place.

## Interface
- NDIG, 4, number of cascaded decade digits (1..8)
- WRAP, 1, 1: roll all-9s to all-0s and keep running; 0: saturate at all-9s and enter DONE
- clk  input  1  single system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  start/resume command, sampled at posedge clk
- stop  input  1  pause command, sampled at posedge clk
- clear  input  1  zero count and return to IDLE, sampled at posedge clk
- x  input  1  count request; one increment per cycle while high in RUN
- out  output  4*NDIG  BCD count; digit 0 (least significant) in out[3:0]
- z  output  1  registered one-cycle pulse on all-9s terminal increment
- run  output  1  high while FSM is in RUN
- done  output  1  high while FSM is in DONE
- lap  input  1  lap toggle (present only with LAP_HOLD_EN)

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Command priority when several are high in one cycle: clear > stop > start.
- IDLE: start -> RUN. clear -> count := 0, stay IDLE. x is ignored.
- RUN: clear -> IDLE with count := 0. stop -> PAUSE. Otherwise, x=1 increments the count.
- PAUSE: clear -> IDLE with count := 0. start -> RUN. x is ignored.
- DONE: clear -> IDLE with count := 0. start, stop and x are ignored.
- Increment rule: digit i advances when x=1 and digits 0..i-1 all equal 9. A digit at 9 rolls to 0. Any code 10..15 is treated as 9 and rolls to 0.
- Terminal increment (all digits 9, x=1, RUN):
  - WRAP=1: count := 0, z=1 for one cycle, stay in RUN.
  - WRAP=0: count holds all-9s, z=1 for one cycle, go to DONE.
- x in the same cycle as a stop or clear command produces no increment.
- Outputs after reset: out=0, z=0, run=0, done=0, state=IDLE.
- Reset asserted mid-count forces all outputs to reset values immediately (asynchronously).

## Timing
- Command latency is 1 cycle. The state changes on the sampling edge, and run/done reflect the new state after that edge.
- The first increment after start occurs on the edge following the start edge, provided x=1 then.
- Count latency is 1 cycle: out shows the new value after the edge where x=1 is sampled in RUN.
- z rises on the same edge the terminal increment is registered and falls on the next edge.
- No combinational path from any input to any output. All outputs are registered.

## Configuration
- LAP_HOLD_EN defined:
  - Adds the lap input and a snapshot register.
  - A lap pulse in RUN freezes out at the current count while the internal count keeps advancing. A second lap pulse unfreezes.
  - stop, clear or reset also release the freeze. After a release, out shows the live count on the next cycle.
  - z and done always track the internal count, never the frozen value.
- LAP_HOLD_EN undefined: no lap port, no snapshot register; out is the live count.

## Structure
- Shared package decade_ctrl_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3
  - BCD_MAX=4'd9
  - DIGIT_W=4
- Sub-module bcd_digit: one decade cell, instantiated NDIG times by a generate loop.
  - Inputs: clk, reset, en, clr.
  - Outputs: value[3:0], tc (value==9).
  - The chain enable is formed as the AND of lower-digit tc signals with the gated x.

## Test plan
- Reset, then start, then x high for 12 cycles (NDIG=4) -> out=16'h0012, run=1, z never asserted.
- Preload via 9999 increments with WRAP=1, then one more x -> out=16'h0000, z high for exactly one cycle, run stays 1.
- Same sequence with WRAP=0 -> out holds 16'h9999, z pulses once, done=1. Further x and start have no effect until clear, after which out=0 and the FSM is in IDLE.
- In RUN at count 0x0005, assert stop and x together -> count stays 0x0005 in PAUSE. start, then 3 x cycles -> 0x0008.
- Assert start, stop and clear in the same cycle from RUN at 0x0042 -> IDLE, out=0, run=0. Assert reset mid-count -> out=0 immediately, without waiting for a clock edge.
- With LAP_HOLD_EN: lap at count 0x0010, then 5 x cycles -> out stays 0x0010. Second lap -> out=0x0015 on the next cycle.

Source files
------------

// File: rtl/decade_ctrl_pkg.sv
// Shared types and constants for the decade counter chain controller.
// Holds the FSM state encoding and BCD digit constants.
package decade_ctrl_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade cell of the counter chain.
// Ports: clk, reset (async, high), en (advance), clr (sync zero),
//        value (BCD digit), tc (digit at terminal value).
module bcd_digit
    import decade_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    output logic [DIGIT_W-1:0] value,
    output logic               tc
);

    // Illegal codes 10..15 behave as 9 so the chain always recovers.
    assign tc = (value >= BCD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (en)
            value <= tc ? '0 : value + 1'b1;
    end

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run/stop/clear controller owning an NDIG-digit cascaded BCD count.
// Ports: clk, reset (async, high), start/stop/clear commands, x (count
//        request), out (BCD count), z (terminal pulse), run, done.
//        LAP_HOLD_EN adds lap and a snapshot that can freeze out.
module decade_chain_ctrl
    import decade_ctrl_pkg::*;
#(
    parameter int NDIG = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    input  logic                      x,
`ifdef LAP_HOLD_EN
    input  logic                      lap,
`endif
    output logic [DIGIT_W*NDIG-1:0]   out,
    output logic                      z,
    output logic                      run,
    output logic                      done
);

    state_t state_q, state_d;
    logic inc, term, all_tc;
    logic [NDIG-1:0] en, tc;
    logic [DIGIT_W*NDIG-1:0] cnt;

    assign all_tc = &tc;

    // Commands resolve as clear > stop > start.
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        term    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!clear && !stop && start)
                    state_d = RUN;
            end
            RUN: begin
                if (clear)
                    state_d = IDLE;
                else if (stop)
                    state_d = PAUSE;
                else if (x) begin
                    term = all_tc;
                    // Saturating build holds at all-9s instead of rolling.
                    inc  = !(all_tc && !WRAP);
                    if (all_tc && !WRAP)
                        state_d = DONE;
                end
            end
            PAUSE: begin
                if (clear)
                    state_d = IDLE;
                else if (!stop && start)
                    state_d = RUN;
            end
            DONE: begin
                if (clear)
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            z       <= 1'b0;
        end else begin
            state_q <= state_d;
            z       <= term;
        end
    end

    assign run  = (state_q == RUN);
    assign done = (state_q == DONE);

    assign en[0] = inc;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        if (i > 0) begin : g_en
            assign en[i] = en[i-1] & tc[i-1];
        end
        bcd_digit u_dig (
            .clk   (clk),
            .reset (reset),
            .en    (en[i]),
            .clr   (clear),
            .value (cnt[i*DIGIT_W +: DIGIT_W]),
            .tc    (tc[i])
        );
    end

`ifdef LAP_HOLD_EN
    logic frozen;
    logic [DIGIT_W*NDIG-1:0] snap;

    // Freeze captures the pre-increment count; stop/clear always release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frozen <= 1'b0;
            snap   <= '0;
        end else if (clear || stop) begin
            frozen <= 1'b0;
        end else if (lap && state_q == RUN) begin
            frozen <= !frozen;
            snap   <= cnt;
        end
    end

    assign out = frozen ? snap : cnt;
`else
    assign out = cnt;
`endif

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Self-checking bench for decade_chain_ctrl (NDIG=4).
// Drives one wrapping and one saturating instance from shared stimulus.
module tb_decade_chain_ctrl;

    logic clk = 1'b0;
    logic reset, start, stop, clear, x;
`ifdef LAP_HOLD_EN
    logic lap;
`endif
    logic [15:0] out_w, out_s;
    logic z_w, z_s, run_w, run_s, done_w, done_s;

    int n_chk = 0;
    int n_fail = 0;
    int zc;

    always #5 clk = ~clk;

    decade_chain_ctrl #(.NDIG(4), .WRAP(1'b1)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .clear (clear),
        .x     (x),
`ifdef LAP_HOLD_EN
        .lap   (lap),
`endif
        .out   (out_w),
        .z     (z_w),
        .run   (run_w),
        .done  (done_w)
    );

    decade_chain_ctrl #(.NDIG(4), .WRAP(1'b0)) u_sat (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .clear (clear),
        .x     (x),
`ifdef LAP_HOLD_EN
        .lap   (lap),
`endif
        .out   (out_s),
        .z     (z_s),
        .run   (run_s),
        .done  (done_s)
    );

    typedef struct {
        logic        st, sp, cl, xx;
        int          rep;
        logic [15:0] o;
        logic        z, r, d;
        string       nm;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl[NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic p,
                         input logic c, input logic xx);
        start = s;
        stop  = p;
        clear = c;
        x     = xx;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0,  1, 16'h0000, 0,1,0, "start"};
        tbl[1]  = '{0,0,0,1, 12, 16'h0012, 0,1,0, "x12"};
        tbl[2]  = '{0,0,1,0,  1, 16'h0000, 0,0,0, "clr_run"};
        tbl[3]  = '{0,0,0,1,  3, 16'h0000, 0,0,0, "x_idle"};
        tbl[4]  = '{1,0,0,0,  1, 16'h0000, 0,1,0, "start2"};
        tbl[5]  = '{0,0,0,1,  5, 16'h0005, 0,1,0, "x5"};
        tbl[6]  = '{0,1,0,1,  1, 16'h0005, 0,0,0, "stop_x"};
        tbl[7]  = '{0,0,0,1,  2, 16'h0005, 0,0,0, "x_pause"};
        tbl[8]  = '{1,0,0,0,  1, 16'h0005, 0,1,0, "resume"};
        tbl[9]  = '{0,0,0,1,  3, 16'h0008, 0,1,0, "x3"};
        tbl[10] = '{0,0,0,1, 34, 16'h0042, 0,1,0, "x34"};
        tbl[11] = '{1,1,1,0,  1, 16'h0000, 0,0,0, "all_cmd"};
        tbl[12] = '{1,0,0,0,  1, 16'h0000, 0,1,0, "start3"};
        tbl[13] = '{0,0,0,1,  9, 16'h0009, 0,1,0, "x9"};
        tbl[14] = '{0,0,0,1,  1, 16'h0010, 0,1,0, "carry1"};
        tbl[15] = '{0,0,0,1, 89, 16'h0099, 0,1,0, "x89"};
        tbl[16] = '{0,0,0,1,  1, 16'h0100, 0,1,0, "carry2"};
        tbl[17] = '{1,1,0,0,  1, 16'h0100, 0,0,0, "stop_vs_start"};
        tbl[18] = '{1,0,0,0,  1, 16'h0100, 0,1,0, "start4"};

        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        x     = 1'b0;
`ifdef LAP_HOLD_EN
        lap   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst out", out_w, 16'h0000);
        chk("rst z", z_w, 0);
        chk("rst run", run_w, 0);
        chk("rst done", done_w, 0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < tbl[i].rep; k++)
                drive(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].xx);
            chk({tbl[i].nm, " out_w"}, out_w, tbl[i].o);
            chk({tbl[i].nm, " out_s"}, out_s, tbl[i].o);
            chk({tbl[i].nm, " z"}, z_w, tbl[i].z);
            chk({tbl[i].nm, " run"}, run_w, tbl[i].r);
            chk({tbl[i].nm, " done"}, done_w, tbl[i].d);
        end

        // Asynchronous reset in the middle of a count.
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("pre_rst out", out_w, 16'h0102);
        x = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst out_w", out_w, 16'h0000);
        chk("async_rst out_s", out_s, 16'h0000);
        chk("async_rst run", run_w, 0);
        #1 reset = 1'b0;

        // Full-range preload to all-9s.
        pulse_reset();
        drive(1, 0, 0, 0);
        zc = 0;
        for (int i = 0; i < 9999; i++) begin
            drive(0, 0, 0, 1);
            zc += int'(z_w) + int'(z_s);
        end
        chk("pre9 out_w", out_w, 16'h9999);
        chk("pre9 out_s", out_s, 16'h9999);
        chk("pre9 z_cnt", zc, 0);

        drive(0, 0, 0, 1);
        chk("term wrap out", out_w, 16'h0000);
        chk("term wrap z", z_w, 1);
        chk("term wrap run", run_w, 1);
        chk("term sat out", out_s, 16'h9999);
        chk("term sat z", z_s, 1);
        chk("term sat done", done_s, 1);
        chk("term sat run", run_s, 0);

        drive(0, 0, 0, 1);
        chk("post wrap out", out_w, 16'h0001);
        chk("post wrap z", z_w, 0);
        chk("post sat z", z_s, 0);
        chk("post sat out", out_s, 16'h9999);

        drive(1, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("done hold out", out_s, 16'h9999);
        chk("done hold done", done_s, 1);
        chk("done hold z", z_s, 0);
        chk("wrap keep out", out_w, 16'h0003);

        drive(0, 0, 1, 0);
        chk("clr done out", out_s, 16'h0000);
        chk("clr done done", done_s, 0);
        chk("clr done run", run_s, 0);
        drive(0, 0, 0, 1);
        chk("idle x out_s", out_s, 16'h0000);
        chk("idle x out_w", out_w, 16'h0000);

`ifdef LAP_HOLD_EN
        pulse_reset();
        drive(1, 0, 0, 0);
        repeat (10) drive(0, 0, 0, 1);
        chk("lap pre out", out_w, 16'h0010);
        lap = 1'b1;
        drive(0, 0, 0, 0);
        lap = 1'b0;
        repeat (5) drive(0, 0, 0, 1);
        chk("lap frozen out", out_w, 16'h0010);
        lap = 1'b1;
        drive(0, 0, 0, 0);
        lap = 1'b0;
        chk("lap release out", out_w, 16'h0015);
        lap = 1'b1;
        drive(0, 0, 0, 1);
        lap = 1'b0;
        drive(0, 0, 0, 1);
        chk("lap2 frozen out", out_w, 16'h0015);
        drive(0, 1, 0, 0);
        chk("lap stop out", out_w, 16'h0017);
`endif

        drive(0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
